// File: rtl/game_pkg.sv
// Shared types for the penalty-game sequencer: screen states, play mode and the
// pending screen-change payload.
package game_pkg;

    localparam int unsigned SCORE_W = 4;

    typedef enum logic [2:0] {
        START   = 3'd0,
        KEEPER  = 3'd1,
        SHOOTER = 3'd2,
        WINNER  = 3'd3,
        LOOSER  = 3'd4
    } game_state_t;

    typedef enum logic {
        SINGLE = 1'b0,
        MULTI  = 1'b1
    } game_mode_t;

    // Everything that changes together when a frame-boundary commit happens
    typedef struct packed {
        game_state_t          state;
        game_mode_t           mode;
        logic [SCORE_W-1:0]   rounds;
        logic [SCORE_W-1:0]   player;
        logic [SCORE_W-1:0]   opp;
        logic                 scored;
    } game_req_t;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                   input logic               inc);
        if (inc && (v != {SCORE_W{1'b1}})) return v + SCORE_W'(1);
        return v;
    endfunction

endpackage

// File: rtl/game_fsm_ctrl_frame_edge_det.sv
// Rising-edge detector for vblnk; the pulse marks the first cycle vblnk is seen high.
module frame_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic vblnk,
    output logic frame_edge_c
);
    logic vblnk_q;

    always_ff @(posedge clk) begin
        if (rst) vblnk_q <= 1'b0;
        else     vblnk_q <= vblnk;
    end

    assign frame_edge_c = vblnk & ~vblnk_q;

endmodule

// File: rtl/game_fsm_ctrl.sv
// Penalty-game sequencer: turns, scores and screen state, with every change held
// in a pending register and committed only at a frame boundary.
module game_fsm_ctrl
    import game_pkg::*;
#(
    parameter int unsigned ROUNDS       = 5,
    parameter int unsigned MAX_ROUNDS   = 15,
    parameter int unsigned SHOT_TIMEOUT = 200_000_000,
    parameter int unsigned END_HOLD     = 300
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_btn,
    input  logic               mode_sel,
    input  logic               shot_done,
    input  logic               goal,
    input  logic               vblnk,
    output game_state_t        game_state,
    output game_mode_t         game_mode,
    output logic [SCORE_W-1:0] round_counter,
    output logic [SCORE_W-1:0] score_player,
    output logic [SCORE_W-1:0] score_opp,
    output logic               is_scored,
    output logic               turn_active
);
    localparam int unsigned TMR_W  = (SHOT_TIMEOUT > 1) ? $clog2(SHOT_TIMEOUT) : 1;
    localparam int unsigned HOLD_W = (END_HOLD > 1) ? $clog2(END_HOLD) : 1;

    logic               frame_edge;
    logic               pend, pend_n;
    game_req_t          req, req_n, cur;
    logic [TMR_W-1:0]   tmr, tmr_n;
    logic [HOLD_W-1:0]  hold, hold_n;
    game_state_t        state_n, kp_next;
    game_mode_t         mode_n;
    logic [SCORE_W-1:0] round_n, player_n, opp_n, kp_opp, kp_round;
    logic               scored_n, active_n;
    logic               timeout, resolve, result, hold_done;

    frame_edge_det u_edge (
        .clk          (clk),
        .rst          (rst),
        .vblnk        (vblnk),
        .frame_edge_c (frame_edge)
    );

    assign cur = '{state: game_state, mode: game_mode, rounds: round_counter,
                   player: score_player, opp: score_opp, scored: is_scored};

    // A timeout resolves the turn as a miss; a coincident shot_done carries its goal
    assign timeout   = (tmr == TMR_W'(SHOT_TIMEOUT - 1));
    assign resolve   = turn_active && !pend && (shot_done || timeout);
    assign result    = shot_done && goal;
    assign hold_done = (hold == HOLD_W'(END_HOLD - 1));
    assign kp_opp    = sat_inc(score_opp, result);
    assign kp_round  = sat_inc(round_counter, 1'b1);

    // End-of-round decision on the post-update round count and scores
    always_comb begin
        kp_next = LOOSER;
        if (kp_round < SCORE_W'(ROUNDS))
            kp_next = SHOOTER;
        else if (score_player != kp_opp)
            kp_next = (score_player > kp_opp) ? WINNER : LOOSER;
        else if (kp_round < SCORE_W'(MAX_ROUNDS))
            kp_next = SHOOTER;
    end

    always_comb begin
        state_n  = game_state;
        mode_n   = game_mode;
        round_n  = round_counter;
        player_n = score_player;
        opp_n    = score_opp;
        scored_n = is_scored;
        active_n = turn_active;
        pend_n   = pend;
        req_n    = req;
        tmr_n    = tmr;
        hold_n   = hold;

        if (pend) begin
            if (frame_edge) begin
                state_n  = req.state;
                mode_n   = req.mode;
                round_n  = req.rounds;
                player_n = req.player;
                opp_n    = req.opp;
                scored_n = req.scored;
                active_n = (req.state == SHOOTER) || (req.state == KEEPER);
                pend_n   = 1'b0;
                tmr_n    = '0;
                hold_n   = '0;
            end
        end else begin
            req_n = cur;
            case (game_state)
                START: begin
                    if (start_btn) begin
                        pend_n       = 1'b1;
                        req_n.state  = SHOOTER;
                        req_n.mode   = game_mode_t'(mode_sel);
                        req_n.rounds = '0;
                        req_n.player = '0;
                        req_n.opp    = '0;
                        req_n.scored = 1'b0;
                    end
                end
                SHOOTER: begin
                    if (resolve) begin
                        pend_n       = 1'b1;
                        req_n.state  = KEEPER;
                        req_n.player = sat_inc(score_player, result);
                        req_n.scored = result;
                    end
                end
                KEEPER: begin
                    if (resolve) begin
                        pend_n       = 1'b1;
                        req_n.state  = kp_next;
                        req_n.opp    = kp_opp;
                        req_n.rounds = kp_round;
                        req_n.scored = result;
                    end
                end
                WINNER, LOOSER: begin
                    if (start_btn || hold_done) begin
                        pend_n      = 1'b1;
                        req_n.state = START;
                    end else if (frame_edge) begin
                        hold_n = hold + HOLD_W'(1);
                    end
                end
                default: begin
                    pend_n      = 1'b1;
                    req_n.state = START;
                end
            endcase

            if (pend_n)           active_n = 1'b0;
            else if (turn_active) tmr_n    = tmr + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            game_state    <= START;
            game_mode     <= MULTI;
            round_counter <= '0;
            score_player  <= '0;
            score_opp     <= '0;
            is_scored     <= 1'b0;
            turn_active   <= 1'b0;
            pend          <= 1'b0;
            req           <= '0;
            tmr           <= '0;
            hold          <= '0;
        end else begin
            game_state    <= state_n;
            game_mode     <= mode_n;
            round_counter <= round_n;
            score_player  <= player_n;
            score_opp     <= opp_n;
            is_scored     <= scored_n;
            turn_active   <= active_n;
            pend          <= pend_n;
            req           <= req_n;
            tmr           <= tmr_n;
            hold          <= hold_n;
        end
    end

endmodule

// File: tb/tb_game_fsm_ctrl.sv
// Directed scenarios plus random play for game_fsm_ctrl, checked every cycle
// against a rule-level model of the game.
module tb_game_fsm_ctrl;
    import game_pkg::*;

    localparam int ROUNDS       = 3;
    localparam int MAX_ROUNDS   = 5;
    localparam int SHOT_TIMEOUT = 100;
    localparam int END_HOLD     = 2;
    localparam int FRAME        = 50;

    logic        clk = 1'b0;
    logic        rst, start_btn, mode_sel, shot_done, goal, vblnk;
    game_state_t game_state;
    game_mode_t  game_mode;
    logic [3:0]  round_counter, score_player, score_opp;
    logic        is_scored, turn_active;

    game_fsm_ctrl #(
        .ROUNDS       (ROUNDS),
        .MAX_ROUNDS   (MAX_ROUNDS),
        .SHOT_TIMEOUT (SHOT_TIMEOUT),
        .END_HOLD     (END_HOLD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_btn     (start_btn),
        .mode_sel      (mode_sel),
        .shot_done     (shot_done),
        .goal          (goal),
        .vblnk         (vblnk),
        .game_state    (game_state),
        .game_mode     (game_mode),
        .round_counter (round_counter),
        .score_player  (score_player),
        .score_opp     (score_opp),
        .is_scored     (is_scored),
        .turn_active   (turn_active)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        game_state_t st;
        int          mode;
        int          rc;
        int          sp;
        int          so;
        int          sc;
    } view_t;

    view_t m;          // what the screen currently shows
    view_t pq[$];      // screen change waiting for a frame boundary
    bit    m_vb_prev;
    int    m_tmr;      // active cycles already spent in this turn
    int    m_frames;   // frame edges seen on the end screen

    function automatic int sat(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    function automatic bit m_active();
        return ((m.st == SHOOTER) || (m.st == KEEPER)) && (pq.size() == 0);
    endfunction

    function automatic game_state_t after_keeper(input int rc, input int sp, input int so);
        if (rc < ROUNDS) return SHOOTER;
        if (sp > so)     return WINNER;
        if (sp < so)     return LOOSER;
        return (rc < MAX_ROUNDS) ? SHOOTER : LOOSER;
    endfunction

    task automatic model_step(input logic r, input logic sb, input logic ms,
                              input logic sd, input logic g, input logic vb);
        bit    edge_now;
        int    res;
        view_t nx;
        if (r) begin
            m = '{st: START, mode: 1, rc: 0, sp: 0, so: 0, sc: 0};
            pq.delete();
            m_vb_prev = 1'b0;
            m_tmr     = 0;
            m_frames  = 0;
            return;
        end
        edge_now  = vb && !m_vb_prev;
        m_vb_prev = vb;
        if (pq.size() != 0) begin
            if (edge_now) begin
                m        = pq.pop_front();
                m_tmr    = 0;
                m_frames = 0;
            end
            return;
        end
        nx = m;
        case (m.st)
            START: if (sb) begin
                nx = '{st: SHOOTER, mode: int'(ms), rc: 0, sp: 0, so: 0, sc: 0};
                pq.push_back(nx);
            end
            SHOOTER, KEEPER: begin
                if (sd || (m_tmr == SHOT_TIMEOUT - 1)) begin
                    res   = sd ? int'(g) : 0;
                    nx.sc = res;
                    if (m.st == SHOOTER) begin
                        nx.st = KEEPER;
                        nx.sp = sat(m.sp + res);
                    end else begin
                        nx.so = sat(m.so + res);
                        nx.rc = sat(m.rc + 1);
                        nx.st = after_keeper(nx.rc, nx.sp, nx.so);
                    end
                    pq.push_back(nx);
                end else begin
                    m_tmr++;
                end
            end
            WINNER, LOOSER: begin
                if (sb || (m_frames == END_HOLD - 1)) begin
                    nx.st = START;
                    pq.push_back(nx);
                end else if (edge_now) begin
                    m_frames++;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic compare_all();
        check_eq("game_state",    32'(game_state),    32'(m.st));
        check_eq("game_mode",     32'(game_mode),     32'(m.mode));
        check_eq("round_counter", 32'(round_counter), 32'(m.rc));
        check_eq("score_player",  32'(score_player),  32'(m.sp));
        check_eq("score_opp",     32'(score_opp),     32'(m.so));
        check_eq("is_scored",     32'(is_scored),     32'(m.sc));
        check_eq("turn_active",   32'(turn_active),   32'(m_active()));
    endtask

    task automatic tick(input logic r, input logic sb, input logic ms,
                        input logic sd, input logic g);
        logic vb;
        vb        = ((cyc % FRAME) < 5);
        rst       = r;
        start_btn = sb;
        mode_sel  = ms;
        shot_done = sd;
        goal      = g;
        vblnk     = vb;
        model_step(r, sb, ms, sd, g, vb);
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_active();
        for (int i = 0; (i < 300) && !m_active(); i++) idle(1);
        check_eq("wait_active", 32'(turn_active), 32'd1);
    endtask

    task automatic wait_commit();
        for (int i = 0; (i < 200) && (pq.size() != 0); i++) idle(1);
        check_eq("wait_commit", 32'(pq.size()), 32'd0);
    endtask

    task automatic play_turn(input int delay, input logic g);
        wait_active();
        idle(delay);
        tick(1'b0, 1'b0, 1'b0, 1'b1, g);
    endtask

    task automatic play_round(input logic gp, input logic go);
        play_turn(3 + int'($urandom_range(0, 20)), gp);
        wait_commit();
        play_turn(3 + int'($urandom_range(0, 20)), go);
        wait_commit();
    endtask

    initial begin
        logic r_rnd;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_state", 32'(game_state), 32'(START));
        check_eq("rst_mode",  32'(game_mode),  32'(MULTI));

        // Start in SINGLE; nothing changes before the next frame edge
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("start_held", 32'(game_state), 32'(START));
        wait_commit();
        check_eq("start_mode",   32'(game_mode),   32'(SINGLE));
        check_eq("start_active", 32'(turn_active), 32'd1);

        // Goal then save, then the rest of a 3-1 game
        play_round(1'b1, 1'b0);
        check_eq("r1_player", 32'(score_player),  32'd1);
        check_eq("r1_opp",    32'(score_opp),     32'd0);
        check_eq("r1_rounds", 32'(round_counter), 32'd1);
        check_eq("r1_state",  32'(game_state),    32'(SHOOTER));
        play_round(1'b1, 1'b1);
        play_round(1'b1, 1'b0);
        check_eq("win_state", 32'(game_state), 32'(WINNER));
        idle(3 * FRAME);
        check_eq("hold_start", 32'(game_state),   32'(START));
        check_eq("hold_score", 32'(score_player), 32'd3);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_commit();
        check_eq("restart_score", 32'(score_player), 32'd0);
        check_eq("restart_mode",  32'(game_mode),    32'(MULTI));

        // 2-2 after regulation, still tied at the cap
        play_round(1'b1, 1'b1);
        play_round(1'b0, 1'b0);
        play_round(1'b1, 1'b1);
        check_eq("sd_state",  32'(game_state),    32'(SHOOTER));
        check_eq("sd_rounds", 32'(round_counter), 32'd3);
        play_round(1'b0, 1'b0);
        play_round(1'b1, 1'b1);
        check_eq("cap_state", 32'(game_state), 32'(LOOSER));

        // Timeout miss (trailing shot lands while pending), then shot on the timeout cycle
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_commit();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_commit();
        play_turn(SHOT_TIMEOUT, 1'b1);
        wait_commit();
        check_eq("to_scored", 32'(is_scored),    32'd0);
        check_eq("to_player", 32'(score_player), 32'd0);
        play_turn(SHOT_TIMEOUT - 1, 1'b1);
        wait_commit();
        check_eq("tie_scored", 32'(is_scored), 32'd1);
        check_eq("tie_opp",    32'(score_opp), 32'd1);

        // Reset while a request is pending
        play_turn(10, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rstp_state",  32'(game_state),  32'(START));
        check_eq("rstp_active", 32'(turn_active), 32'd0);
        idle(FRAME + 10);
        check_eq("rstp_nocommit", 32'(game_state), 32'(START));

        // Random play
        for (int i = 0; i < 12000; i++) begin
            r_rnd = ($urandom_range(0, 3999) == 0);
            tick(r_rnd,
                 $urandom_range(0, 79) == 0,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 44) == 0,
                 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/game_fsm_ctrl.md
# game_fsm_ctrl

Game sequencer that drives `game_state`, `game_mode`, round counter and scores for the penalty simulator. It sits upstream of the screen selector and the per-screen renderers. It consumes one-cycle round-result pulses and the start button, and commits state changes only at a frame boundary (rising edge of `vblnk`) so the displayed screen never switches mid-frame.

## Interface
Parameters:
- `ROUNDS`, 5, regular rounds; one round is one shooter turn plus one keeper turn.
- `MAX_ROUNDS`, 15, sudden-death cap; must be ≥ `ROUNDS` and ≤ 15.
- `SHOT_TIMEOUT`, 200_000_000, clk cycles allowed per turn before it is forced to resolve as "no goal".
- `END_HOLD`, 300, frames spent in WINNER/LOOSER before automatic return to START.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start_btn`  in  1  debounced one-cycle pulse.
- `mode_sel`  in  1  0 = SINGLE, 1 = MULTI; sampled only when START is left.
- `shot_done`  in  1  one-cycle pulse: the current turn is resolved.
- `goal`  in  1  qualified by `shot_done`; 1 = ball in net.
- `vblnk`  in  1  vertical blank from the VGA timing chain.
- `game_state`  out  game_state_t  current screen.
- `game_mode`  out  game_mode_t  mode latched at game start.
- `round_counter`  out  4  completed rounds.
- `score_player`  out  4  player goals.
- `score_opp`  out  4  opponent goals.
- `is_scored`  out  1  result of the last resolved turn.
- `turn_active`  out  1  high while a turn accepts `shot_done`.

## Operation
- Reset values: `game_state`=START, `game_mode`=MULTI, `round_counter`=0, both scores 0, `is_scored`=0, `turn_active`=0, pending flag clear, timers 0.
- Requests (next state plus score updates) are computed into a pending register. While a request is pending, `turn_active`=0, and `shot_done`, `start_btn` and timeout are ignored.
- START: `start_btn` requests SHOOTER and latches `mode_sel`. The commit clears scores, `round_counter` and `is_scored`.
- SHOOTER, on `shot_done` or timeout:
  - `score_player += goal` (timeout counts as goal = 0).
  - `is_scored` = that result.
  - Request KEEPER.
- KEEPER, on `shot_done` or timeout:
  - `score_opp += goal`, `is_scored` updated, `round_counter += 1`.
  - Then decide with the new values:
    - `round_counter < ROUNDS` → SHOOTER.
    - Scores differ → WINNER if `score_player > score_opp`, else LOOSER.
    - Tie and `round_counter < MAX_ROUNDS` → SHOOTER (sudden death).
    - Tie at `MAX_ROUNDS` → LOOSER.
- No early decision before `ROUNDS`.
- WINNER/LOOSER: `start_btn` or `END_HOLD` frame edges request START.
- Turn timer: clears on every commit and counts while `turn_active`. It fires when the count equals `SHOT_TIMEOUT-1`.
- If `shot_done` and timeout occur in the same cycle, `shot_done` (with its `goal`) wins.
- Score and round arithmetic is 4-bit and saturates at 15; it never wraps.
- An unknown state is treated as START on the next commit.

## Timing
- Frame edge = `vblnk` 0→1, detected with one register. The edge is valid on the cycle after the transition.
- Commit happens on the frame-edge cycle if a request is pending. All outputs update together at the next clk edge.
- Latency: pulse → outputs change at the first frame edge that is strictly after the pulse cycle, plus 1 cycle.
- A request raised in the same cycle as a frame edge waits for the following edge.
- `turn_active` rises one cycle after a commit into SHOOTER/KEEPER. It falls the cycle after a request is raised.
- `is_scored` and scores change only at commit, never at the pulse.
- Reset mid-game: all outputs return to reset values on the next clk edge, and the pending request is discarded.

## Structure
- `game_pkg` holds:
  - `game_state_t` {START, KEEPER, SHOOTER, WINNER, LOOSER}.
  - `game_mode_t` {SINGLE, MULTI}.
  - Score width constant = 4.
- Sub-module `frame_edge_det`: registers `vblnk` and outputs a one-cycle rising-edge pulse.
- Main module contains the FSM, pending register, turn timer and hold counter.

## Test plan
Bench parameters: `ROUNDS`=3, `MAX_ROUNDS`=5, `SHOT_TIMEOUT`=100, `END_HOLD`=2; frame period 50 cycles.
- Reset then `start_btn` with `mode_sel`=0 → START until the next frame edge, then SHOOTER with `game_mode`=SINGLE and `turn_active`=1 one cycle later.
- Goal in SHOOTER, then save in KEEPER → after commits: `score_player`=1, `score_opp`=0, `round_counter`=1, state back in SHOOTER.
- Three rounds with player 3, opponent 1 → WINNER. After 2 frame edges → START with scores still shown; they clear only after the next start commit.
- Tie 2–2 after 3 rounds → SHOOTER (sudden death). Tie persists to round 5 → LOOSER.
- No `shot_done` for 100 cycles in SHOOTER → turn resolved as miss (`is_scored`=0). `shot_done` with `goal`=1 on the timeout cycle → scored instead.
- Second `shot_done` while a request is pending → ignored, score unchanged. Assert `rst` while pending → all outputs at reset values next cycle, and no commit at the following frame edge.
